rst_seq_ctrl: RTL and testbench

- Board-level reset and run controller. It sits directly downstream of clkdiv_init and consumes its `rst` output.
- Releases the bus, LED/segment display and CPU domains from reset in a fixed staged order.
- Then gates the CPU with a clock enable, either free-running or single-stepped from a push button.
- Also produces the display scan strobe, so all sequencing of the divided-clock resource lives in one block.

---
 rtl/rst_seq_pkg.sv | 7 +
 rtl/sync_edge_det.sv | 49 ++++
 rtl/rst_seq_ctrl.sv | 63 ++++++
 tb/tb_rst_seq_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state encoding and parameter defaults shared by rst_seq_ctrl and its synchronizers
package rst_seq_pkg;
    typedef enum logic [1:0] {HOLD = 2'd0, BUS_UP = 2'd1, SEG_UP = 2'd2, RUN = 2'd3} state_t;
    localparam int STAGE_CYC_DEF = 16;
    localparam int SCAN_DIV_DEF = 50000;
    localparam int DEB_CYC_DEF = 20000;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer with a rising-edge pulse on the synced level
// STEP_DEBOUNCE_EN inserts a DEB_CYC stable-sample debouncer ahead of the edge detect
module sync_edge_det
    import rst_seq_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic nxt,
    output logic rise
);
    logic s2, lvl, lvl_d;
    if (DEB_CYC < 1) begin : g_bad_deb
        $error("DEB_CYC must be at least 1");
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            nxt <= 1'b0;
            s2 <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            nxt <= din;
            s2 <= nxt;
            lvl_d <= lvl;
        end
`ifdef STEP_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    logic [DW-1:0] dcnt;
    // any sample matching the current level restarts the stability count
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lvl <= 1'b0;
            dcnt <= '0;
        end else if (s2 == lvl) begin
            dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
            lvl <= s2;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
`else
    assign lvl = s2;
`endif
    assign rise = lvl & ~lvl_d;
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged bus/seg/cpu reset release, cpu clock enable and display scan strobe
// STEP_DEBOUNCE_EN debounces the step button before step events are taken
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int STAGE_CYC = STAGE_CYC_DEF,
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run_sw,
    input  logic step_btn,
    output logic bus_rst,
    output logic seg_rst,
    output logic cpu_rst,
    output logic cpu_ce,
    output logic seg_tick,
    output logic seq_done
);
    localparam int SW = $clog2(STAGE_CYC + 1);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_CYC - 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    state_t state;
    logic [SW-1:0] cnt;
    logic [CW-1:0] sc;
    logic stage_end, run_nxt, step_rise, run_rise_unused, step_nxt_unused;
    sync_edge_det #(.DEB_CYC(DEB_CYC)) u_run (
        .clk(clk), .rst(rst), .din(run_sw), .nxt(run_nxt), .rise(run_rise_unused)
    );
    sync_edge_det #(.DEB_CYC(DEB_CYC)) u_step (
        .clk(clk), .rst(rst), .din(step_btn), .nxt(step_nxt_unused), .rise(step_rise)
    );
    assign stage_end = cnt == STAGE_LAST;
    // run_nxt is the value the synced run_sw takes at this edge, so free-run stops on that same edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= HOLD;
            cnt <= '0;
            sc <= '0;
            bus_rst <= 1'b1;
            seg_rst <= 1'b1;
            cpu_rst <= 1'b1;
            cpu_ce <= 1'b0;
            seg_tick <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            sc <= (seg_rst || sc == SCAN_LAST) ? '0 : sc + 1'b1;
            seg_tick <= !seg_rst && sc == SCAN_LAST;
            cpu_ce <= state == RUN ? (run_nxt | step_rise) : (state == SEG_UP && stage_end && run_nxt);
            if (state != RUN) begin
                cnt <= stage_end ? '0 : cnt + 1'b1;
                if (stage_end) begin
                    state <= state_t'(state + 2'd1);
                    bus_rst <= bus_rst && state != HOLD;
                    seg_rst <= seg_rst && state != BUS_UP;
                    cpu_rst <= state != SEG_UP;
                    seq_done <= state == SEG_UP;
                end
            end
        end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed checks of release timing, free-run, single-step, scan tick and mid-run reset
module tb_rst_seq_ctrl;
    logic clk = 1'b0, rst = 1'b1, run_sw = 1'b1, step_btn = 1'b0;
    logic bus_rst, seg_rst, cpu_rst, cpu_ce, seg_tick, seq_done;
    logic [5:0] outs;
    int total = 0, bad = 0, e = 0;
    rst_seq_ctrl #(.STAGE_CYC(4), .SCAN_DIV(5), .DEB_CYC(3)) dut (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
        .bus_rst(bus_rst), .seg_rst(seg_rst), .cpu_rst(cpu_rst),
        .cpu_ce(cpu_ce), .seg_tick(seg_tick), .seq_done(seq_done)
    );
    always #5 clk = ~clk;
    assign outs = {bus_rst, seg_rst, cpu_rst, cpu_ce, seg_tick, seq_done};
    // expected {bus_rst, seg_rst, cpu_rst, cpu_ce, seg_tick, seq_done} after edge k of a release
    function automatic logic [5:0] rel(input int k, input logic ce);
        return {k < 4, k < 8, k < 12, ce, k >= 13 && (k - 13) % 5 == 0, k >= 12};
    endfunction
`ifdef STEP_DEBOUNCE_EN
    function automatic logic btn(input int k);
        return (k >= 5 && k < 7) || (k >= 15 && k < 17) || (k >= 25 && k < 31);
    endfunction
    function automatic logic step_ce(input int k);
        return k == 31;
    endfunction
`else
    function automatic logic btn(input int k);
        return (k >= 5 && k < 7) || (k >= 15 && k < 17) || (k >= 25 && k < 27) || (k >= 35 && k < 37);
    endfunction
    function automatic logic step_ce(input int k);
        return k == 18 || k == 28 || k == 38;
    endfunction
`endif
    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic go(input int k);
        while (e < k) begin
            @(posedge clk);
            e++;
        end
        @(negedge clk);
    endtask
    initial begin
        #50;
        check("reset_state", outs, 6'b111000);
        #50;
        rst = 1'b0;
        e = 0;
        for (int k = 1; k <= 25; k++) begin
            go(k);
            check($sformatf("freerun_e%0d", k), outs, rel(k, k >= 12));
        end
        run_sw = 1'b0;
        go(26);
        check("run_off_e26", outs, rel(26, 1'b1));
        go(27);
        check("run_off_e27", outs, rel(27, 1'b0));
        run_sw = 1'b1;
        go(28);
        check("run_on_e28", outs, rel(28, 1'b0));
        go(29);
        check("run_on_e29", outs, rel(29, 1'b1));
        go(30);
        check("run_on_e30", outs, rel(30, 1'b1));
        rst = 1'b1;
        #1;
        check("midrun_async_rst", outs, 6'b111000);
        @(negedge clk);
        check("midrun_rst_held", outs, 6'b111000);
        rst = 1'b0;
        run_sw = 1'b0;
        step_btn = btn(0);
        e = 0;
        for (int k = 1; k <= 45; k++) begin
            go(k);
            check($sformatf("step_e%0d", k), outs, rel(k, step_ce(k)));
            step_btn = btn(k);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
